// File: rtl/prog_lut_eval.sv
// Purpose: evaluates an N-input Boolean function held in a run-time reprogrammable 2^N-bit truth table, with a built-in exhaustive sweep.
// Latency: 1 cycle from an accepted in_valid to out_valid; a sweep emits one vector per cycle, one cycle after entering SWEEP.
// Backpressure: in_ready drops only while sweeping, and in_valid is then ignored; config loads stall on cycles without cfg_valid.
module prog_lut_eval #(
    parameter int                N    = 3,
    parameter logic [2**N-1:0]   INIT = 8'h3A
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_valid,
    input  logic           cfg_bit,
    output logic           cfg_done,
    input  logic           sweep_start,
    input  logic           in_valid,
    input  logic [N-1:0]   in_vec,
    output logic           in_ready,
    output logic           out_valid,
    output logic           F,
    output logic [N-1:0]   out_idx,
    output logic           sweep_done,
    output logic [N:0]     sweep_ones,
    output logic           busy
);

    localparam int TBL = 2**N;

    typedef enum logic [1:0] {
        ST_READY,
        ST_LOAD,
        ST_SWEEP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TBL-1:0]  active_tbl;
    logic [TBL-1:0]  shadow_tbl;
    logic [TBL-1:0]  shadow_wr;
    logic [N-1:0]    load_cnt;
    logic [N-1:0]    sweep_cnt;
    logic [N:0]      ones_acc;
    logic [N:0]      ones_sum;
    logic            cfg_wr;
    logic            load_last;
    logic            sweep_go;
    logic            sweep_emit;
    logic            sweep_bit;

    // cfg_start has priority over sweep_start when both arrive in READY
    assign sweep_go   = (state == ST_READY) && !cfg_start && sweep_start;
    assign cfg_wr     = (state == ST_LOAD) && cfg_valid;
    assign load_last  = cfg_wr && (&load_cnt);
    // sweep_done high means the last vector is on the outputs; the next cycle only exits
    assign sweep_emit = (state == ST_SWEEP) && !sweep_done;
    assign sweep_bit  = active_tbl[sweep_cnt];
    assign ones_sum   = ones_acc + {{N{1'b0}}, sweep_bit};

    assign in_ready   = (state != ST_SWEEP);
    assign busy       = (state != ST_READY);

    // Shadow table with the incoming serial bit merged in, so the final bit can commit in the same edge
    always_comb begin
        shadow_wr           = shadow_tbl;
        shadow_wr[load_cnt] = cfg_bit;
    end

    // Next-state decode; start requests outside READY are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            ST_READY: begin
                if (cfg_start)
                    state_nxt = ST_LOAD;
                else if (sweep_start)
                    state_nxt = ST_SWEEP;
            end
            ST_LOAD: begin
                if (load_last)
                    state_nxt = ST_READY;
            end
            ST_SWEEP: begin
                if (sweep_done)
                    state_nxt = ST_READY;
            end
            default: state_nxt = ST_READY;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_READY;
        else
            state <= state_nxt;
    end

    // Serial table load into the shadow copy, committed to the active table on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_tbl <= INIT;
            shadow_tbl <= '0;
            load_cnt   <= '0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_done <= load_last;
            if ((state == ST_READY) && cfg_start)
                load_cnt <= '0;
            if (cfg_wr) begin
                shadow_tbl <= shadow_wr;
                load_cnt   <= load_cnt + 1'b1;
            end
            if (load_last)
                active_tbl <= shadow_wr;
        end
    end

    // Output register: sweep vectors take the outputs while sweeping, otherwise accepted lookups
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            F          <= 1'b0;
            out_idx    <= '0;
            sweep_done <= 1'b0;
            sweep_ones <= '0;
            sweep_cnt  <= '0;
            ones_acc   <= '0;
        end else begin
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            if (sweep_go) begin
                sweep_cnt <= '0;
                ones_acc  <= '0;
            end
            if (sweep_emit) begin
                out_valid <= 1'b1;
                out_idx   <= sweep_cnt;
                F         <= sweep_bit;
                ones_acc  <= ones_sum;
                sweep_cnt <= sweep_cnt + 1'b1;
                if (&sweep_cnt) begin
                    sweep_done <= 1'b1;
                    sweep_ones <= ones_sum;
                end
            end else if (in_ready && in_valid) begin
                out_valid <= 1'b1;
                out_idx   <= in_vec;
                F         <= active_tbl[in_vec];
            end
        end
    end

endmodule

// File: tb/tb_prog_lut_eval.sv
// Purpose: directed self-checking bench for prog_lut_eval with N=3 and the default table.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the following edge.
// Backpressure: every wait is a fixed cycle count, so the run always reaches its summary.
module tb_prog_lut_eval;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_done;
    logic       sweep_start;
    logic       in_valid;
    logic [2:0] in_vec;
    logic       in_ready;
    logic       out_valid;
    logic       F;
    logic [2:0] out_idx;
    logic       sweep_done;
    logic [3:0] sweep_ones;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    prog_lut_eval #(.N(3), .INIT(8'h3A)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_bit     (cfg_bit),
        .cfg_done    (cfg_done),
        .sweep_start (sweep_start),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .F           (F),
        .out_idx     (out_idx),
        .sweep_done  (sweep_done),
        .sweep_ones  (sweep_ones),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One lookup in READY/LOAD: result is checked one edge later
    task automatic eval(input logic [2:0] v, input logic exp_f);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
        chk("eval_vld", out_valid, 1'b1);
        chk("eval_idx", out_idx, v);
        chk("eval_F", F, exp_f);
    endtask

    task automatic start_load(input logic also_sweep);
        cfg_start   = 1'b1;
        sweep_start = also_sweep;
        step();
        cfg_start   = 1'b0;
        sweep_start = 1'b0;
        chk("load_busy", busy, 1'b1);
        chk("load_rdy", in_ready, 1'b1);
    endtask

    // Feed bits first..last of a table; optional idle gap cycles and commit-cycle lookup probe
    task automatic feed_bits(input logic [7:0] bits, input int first, input int last,
                             input logic gap, input logic probe, input logic [7:0] old_tbl);
        logic [7:0] b;
        b = bits;
        for (int i = first; i <= last; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = b[i];
            if (probe && i == 7) begin
                in_valid = 1'b1;
                in_vec   = 3'd1;
            end
            step();
            cfg_valid = 1'b0;
            if (i == 7) begin
                chk("cfg_done_pulse", cfg_done, 1'b1);
                chk("load_exit_busy", busy, 1'b0);
                if (probe) chk("commit_old_F", F, old_tbl[1]);
                step();
                in_valid = 1'b0;
                chk("cfg_done_clear", cfg_done, 1'b0);
                if (probe) chk("after_new_F", F, b[1]);
            end else begin
                chk("cfg_done_early", cfg_done, 1'b0);
                if (gap) begin
                    step();
                    chk("gap_busy", busy, 1'b1);
                end
            end
        end
    endtask

    task automatic do_sweep(input logic [7:0] tbl, input logic [3:0] exp_ones);
        logic [7:0] t;
        logic [2:0] k;
        int nv;
        t  = tbl;
        nv = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk("sw_busy", busy, 1'b1);
        chk("sw_rdy0", in_ready, 1'b0);
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 3);
            in_vec   = 3'd3;
            step();
            if (out_valid) begin
                k = nv[2:0];
                chk("sw_idx", out_idx, k);
                chk("sw_F", F, t[k]);
                chk("sw_rdy", in_ready, 1'b0);
                chk("sw_done", sweep_done, (nv == 7));
                if (sweep_done) chk("sw_ones_at_done", sweep_ones, exp_ones);
                nv++;
            end
        end
        in_valid = 1'b0;
        chk("sw_count", nv, 8);
        chk("sw_end_busy", busy, 1'b0);
        chk("sw_ones_hold", sweep_ones, exp_ones);
    endtask

    initial begin
        logic [7:0] init_tbl;
        init_tbl    = 8'h3A;
        rst         = 1'b1;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_bit     = 1'b0;
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        in_vec      = '0;
        step();
        step();
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_F", F, 1'b0);
        chk("rst_idx", out_idx, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_ones", sweep_ones, 4'd0);
        chk("rst_cfg_done", cfg_done, 1'b0);
        rst = 1'b0;
        step();

        // Back-to-back lookups of all 8 vectors with the reset table
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_vec   = i[2:0];
            step();
            chk("tt_vld", out_valid, 1'b1);
            chk("tt_idx", out_idx, i[2:0]);
            chk("tt_F", F, init_tbl[i]);
        end
        in_valid = 1'b0;
        step();
        chk("idle_vld", out_valid, 1'b0);
        chk("idle_F_hold", F, 1'b0);
        chk("idle_idx_hold", out_idx, 3'd7);

        do_sweep(8'h3A, 4'd4);

        // All-ones table with gapped config bits, then a sweep that counts 8
        start_load(1'b0);
        feed_bits(8'hFF, 0, 7, 1'b1, 1'b0, 8'h3A);
        do_sweep(8'hFF, 4'd8);

        // Commit-cycle lookup sees the old table, the next one the new table
        start_load(1'b0);
        feed_bits(8'h01, 0, 7, 1'b0, 1'b1, 8'hFF);

        // Simultaneous starts: load wins; starts during LOAD are ignored and do not restart it
        start_load(1'b1);
        step();
        chk("both_no_sweep", out_valid, 1'b0);
        feed_bits(8'hC5, 0, 2, 1'b0, 1'b0, 8'h01);
        cfg_start   = 1'b1;
        sweep_start = 1'b1;
        step();
        cfg_start   = 1'b0;
        sweep_start = 1'b0;
        step();
        chk("ign_busy", busy, 1'b1);
        chk("ign_rdy", in_ready, 1'b1);
        chk("ign_vld", out_valid, 1'b0);
        feed_bits(8'hC5, 3, 7, 1'b0, 1'b0, 8'h01);
        eval(3'd0, 1'b1);
        eval(3'd4, 1'b0);

        // Reset after half a load restores the reset table and clears outputs at once
        start_load(1'b0);
        feed_bits(8'h00, 0, 3, 1'b0, 1'b0, 8'hC5);
        eval(3'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_F", F, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ones", sweep_ones, 4'd0);
        step();
        rst = 1'b0;
        step();
        eval(3'd0, 1'b0);
        eval(3'd4, 1'b1);
        start_load(1'b0);
        feed_bits(8'h81, 0, 7, 1'b0, 1'b0, 8'h3A);
        do_sweep(8'h81, 4'd2);

        // Reset partway through a sweep leaves the count cleared
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("sw_rst_ones", sweep_ones, 4'd0);
        chk("sw_rst_vld", out_valid, 1'b0);
        chk("sw_rst_rdy", in_ready, 1'b1);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_lut_eval.md
Name: prog_lut_eval

Overview:
- Parametrised, registered successor to the team's fixed 3-input gate-level function blocks.
- Evaluates any N-input Boolean function stored as a 2^N-bit truth table.
- The truth table is reprogrammable at run time over a serial config port.
- A built-in sweep mode walks all 2^N input combinations and reports each output plus a count of ones, replacing hand-written exhaustive benches.

Parameters:
- N, 3, number of function inputs (1..6).
- INIT, 8'h3A, truth table loaded at reset, width 2^N; bit k = F for input vector k. Default is F = x ? ~y : z with in_vec = {x,y,z}.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  begins a truth-table load.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial truth-table bit, index 0 first.
- cfg_done  output  1  one-cycle pulse when the new table is committed.
- sweep_start  input  1  begins an exhaustive sweep.
- in_valid  input  1  in_vec is valid this cycle.
- in_vec  input  N  input combination to evaluate.
- in_ready  output  1  high when in_valid is accepted.
- out_valid  output  1  F and out_idx are valid.
- F  output  1  function value.
- out_idx  output  N  input vector that produced F.
- sweep_done  output  1  pulse coinciding with the last sweep output.
- sweep_ones  output  N+1  number of ones produced by the last completed sweep.
- busy  output  1  state is LOAD or SWEEP.

Behaviour:
- Reset (async, immediate): state=READY; active table=INIT; shadow table=0; load counter=0; sweep counter=0; F=0, out_idx=0, out_valid=0, cfg_done=0, sweep_done=0, sweep_ones=0, busy=0; in_ready goes to 1 (combinational from state).
- States: READY, LOAD, SWEEP.
- READY:
  - in_ready=1.
  - in_valid at edge t gives out_valid=1, F=table[in_vec], out_idx=in_vec after edge t, so latency is 1 cycle.
  - With no in_valid, out_valid=0 next cycle; F and out_idx hold their last values.
- READY -> LOAD on cfg_start; load counter cleared. If cfg_start and sweep_start arrive in the same cycle, cfg_start wins and sweep_start is dropped.
- READY -> SWEEP on sweep_start alone; sweep counter and ones accumulator cleared.
- LOAD:
  - Evaluation continues with the old active table: in_ready=1, latency unchanged.
  - Each cfg_valid writes cfg_bit into shadow[counter] and increments the counter. Cycles without cfg_valid stall the load.
  - When bit 2^N-1 is written: shadow copies to the active table at that same edge, cfg_done pulses on the next cycle, state returns to READY.
  - An in_valid in the commit cycle uses the old table. An in_valid in the following cycle uses the new table.
  - cfg_start and sweep_start are ignored in LOAD; cfg_start does not restart the load.
- SWEEP:
  - in_ready=0 and in_valid is ignored.
  - Each cycle k = 0..2^N-1: out_valid=1, out_idx=k, F=table[k]; the ones accumulator adds F.
  - sweep_done=1 in the cycle carrying k=2^N-1. sweep_ones updates to the final count in that same cycle and holds until the next sweep completes.
  - Next cycle: state=READY, out_valid=0. The counter wraps to 0 and is not reused.
  - cfg_start and sweep_start are ignored in SWEEP.
- sweep_ones uses N+1 bits so an all-ones table (count 2^N) does not overflow.
- Reset mid-load discards the shadow table and restores INIT. Reset mid-sweep leaves sweep_ones=0.
- All outputs are registered except in_ready and busy, which are decoded from state.

Test Plan:
- Reset, then in_valid with in_vec = 0..7 on consecutive cycles -> F = 0,1,0,1,1,1,0,0 and out_idx = in_vec, each 1 cycle after its input.
- sweep_start with INIT table -> out_valid high for exactly 8 cycles, out_idx 0..7, F as above; sweep_done on idx 7; sweep_ones=4; in_ready=0 throughout the sweep.
- cfg_start, then bits of 8'hFF with cfg_valid gapped every other cycle -> cfg_done after the 8th bit; next sweep gives sweep_ones=8 with no overflow.
- Load 8'h01 while issuing in_vec=1 in the commit cycle and again in the following cycle -> F=1 (old table), then F=0 (new table).
- cfg_start and sweep_start in the same cycle -> state=LOAD and no sweep outputs; sweep_start during LOAD is ignored.
- Assert rst after 4 of 8 config bits -> outputs clear immediately; in_vec=0 then gives F=0 and in_vec=4 gives F=1 (INIT restored); a subsequent full load still completes.
